// File: rtl/game_state_regs.sv
// game_state_regs: Avalon-MM bank of game-state bytes for the display path.
// Define GAME_REGS_SHADOW_EN for staged writes that commit on frame_start.
module game_state_regs #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [4:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [7:0]  initial_screen,
  output logic [7:0]  card_select,
  output logic [7:0]  my_card_1,
  output logic [7:0]  my_card_2,
  output logic [7:0]  my_card_3,
  output logic [7:0]  my_card_used,
  output logic [7:0]  enemy_card_used,
  output logic [7:0]  enemy_card_visible,
  output logic [7:0]  my_hp,
  output logic [7:0]  my_shield,
  output logic [7:0]  time_num,
  output logic [7:0]  round,
  output logic [7:0]  enemy_hp,
  output logic [7:0]  enemy_shield,
  output logic [7:0]  buff,
  output logic [7:0]  ult_info,
  output logic [7:0]  ending_info,
  output logic [7:0]  show_instr,
  output logic        commit_pending
);
  localparam int         NREG     = 18;
  localparam logic [4:0] A_COMMIT = 5'd18;
  localparam logic [4:0] A_STATUS = 5'd19;

  logic [7:0]             r_live [NREG];
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [31:0]            r_rdata;
  logic                   r_rvalid;
  logic [31:0]            w_rdata;
  logic [31:0]            w_status;
  logic                   w_wr_state;
  logic                   w_pending;
  logic                   w_unused;

  assign w_wr_state = avs_write && (avs_address < 5'(NREG));
  assign w_unused   = ^avs_writedata[31:8];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) r_frame_cnt <= '0;
    else if (frame_start) r_frame_cnt <= r_frame_cnt + 1'b1;
  end

  always_comb begin
    w_status = '0;
    w_status[FRAME_CNT_W:0] = {r_frame_cnt, w_pending};
  end

`ifdef GAME_REGS_SHADOW_EN
  logic [7:0] r_stage [NREG];
  logic       r_pending;
  logic       w_commit_wr;
  logic       w_copy;

  assign w_commit_wr = avs_write && (avs_address == A_COMMIT) && avs_writedata[0];
  // A commit write on the frame_start edge copies at once, never pends
  assign w_copy      = frame_start && (r_pending || w_commit_wr);
  assign w_pending   = r_pending;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_stage[i] <= (i == 0) ? 8'h01 : 8'h00;
    end else if (w_wr_state) begin
      r_stage[avs_address] <= avs_writedata[7:0];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_live[i] <= (i == 0) ? 8'h01 : 8'h00;
    end else if (w_copy) begin
      for (int i = 0; i < NREG; i++) r_live[i] <= r_stage[i];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) r_pending <= 1'b0;
    else if (w_copy) r_pending <= 1'b0;
    else if (w_commit_wr) r_pending <= 1'b1;
  end

  always_comb begin
    w_rdata = '0;
    if (avs_address < 5'(NREG)) w_rdata = {24'b0, r_stage[avs_address]};
    else if (avs_address == A_STATUS) w_rdata = w_status;
  end
`else
  assign w_pending = 1'b0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_live[i] <= (i == 0) ? 8'h01 : 8'h00;
    end else if (w_wr_state) begin
      r_live[avs_address] <= avs_writedata[7:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (avs_address < 5'(NREG)) w_rdata = {24'b0, r_live[avs_address]};
    else if (avs_address == A_STATUS) w_rdata = w_status;
  end
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= avs_read;
      if (avs_read) r_rdata <= w_rdata;
    end
  end

  assign avs_readdata       = r_rdata;
  assign avs_readdatavalid  = r_rvalid;
  assign commit_pending     = w_pending;
  assign initial_screen     = r_live[0];
  assign card_select        = r_live[1];
  assign my_card_1          = r_live[2];
  assign my_card_2          = r_live[3];
  assign my_card_3          = r_live[4];
  assign my_card_used       = r_live[5];
  assign enemy_card_used    = r_live[6];
  assign enemy_card_visible = r_live[7];
  assign my_hp              = r_live[8];
  assign my_shield          = r_live[9];
  assign time_num           = r_live[10];
  assign round              = r_live[11];
  assign enemy_hp           = r_live[12];
  assign enemy_shield       = r_live[13];
  assign buff               = r_live[14];
  assign ult_info           = r_live[15];
  assign ending_info        = r_live[16];
  assign show_instr         = r_live[17];
endmodule

// File: tb/tb_game_state_regs.sv
// tb_game_state_regs: directed tests for game_state_regs.
// Covers the shadow build when GAME_REGS_SHADOW_EN is defined.
module tb_game_state_regs;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        frame_start = 0;
  logic [4:0]  addr = '0;
  logic        wr = 0;
  logic [31:0] wdata = '0;
  logic        rd = 0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  o [18];
  logic        pend;
  logic [135:0] rest;
  logic [15:0] exp_fcnt = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_state_regs #(.FRAME_CNT_W(16)) dut (
    .vga_clk(clk), .reset_n(rst_n), .frame_start(frame_start),
    .avs_address(addr), .avs_write(wr), .avs_writedata(wdata),
    .avs_read(rd), .avs_readdata(rdata), .avs_readdatavalid(rvalid),
    .initial_screen(o[0]), .card_select(o[1]), .my_card_1(o[2]),
    .my_card_2(o[3]), .my_card_3(o[4]), .my_card_used(o[5]),
    .enemy_card_used(o[6]), .enemy_card_visible(o[7]), .my_hp(o[8]),
    .my_shield(o[9]), .time_num(o[10]), .round(o[11]),
    .enemy_hp(o[12]), .enemy_shield(o[13]), .buff(o[14]),
    .ult_info(o[15]), .ending_info(o[16]), .show_instr(o[17]),
    .commit_pending(pend)
  );

  assign rest = {o[1], o[2], o[3], o[4], o[5], o[6], o[7], o[8], o[9],
                 o[10], o[11], o[12], o[13], o[14], o[15], o[16], o[17]};

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1;
    @(posedge clk); #1;
    wr = 0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d,
                        output logic v);
    addr = a; rd = 1;
    @(posedge clk); #1;
    rd = 0;
    d = rdata; v = rvalid;
  endtask

  task automatic pulse_frame();
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
    exp_fcnt = exp_fcnt + 16'd1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    #1;
    checks++;
    if (o[0] !== 8'h01) begin
      errors++; $display("FAIL reset_screen got %h want 01", o[0]);
    end
    checks++;
    if (rest !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", rest);
    end
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus got %b/%h want 0/0", rvalid, rdata);
    end
    checks++;
    if (pend !== 1'b0) begin
      errors++; $display("FAIL reset_pending got %b want 0", pend);
    end
    @(posedge clk); #1;
    bus_rd(5'd19, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL reset_status got %b/%h want 1/0", v, d);
    end
    @(posedge clk); #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL rvalid_drop got %b want 0", rvalid);
    end
    bus_rd(5'd0, d, v);
    checks++;
    if (d !== 32'h01) begin
      errors++; $display("FAIL reset_rd0 got %h want 01", d);
    end
  endtask

  task automatic test_reserved();
    logic [31:0] d;
    logic v;
    bus_wr(5'd25, 32'hFFFF_FFFF);
    bus_rd(5'd25, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL rsvd_read got %b/%h want 1/0", v, d);
    end
    checks++;
    if (o[0] !== 8'h01 || rest !== '0 || pend !== 1'b0) begin
      errors++; $display("FAIL rsvd_write got %h/%h/%b want 01/0/0", o[0], rest, pend);
    end
  endtask

  task automatic test_frame_wrap();
    logic [31:0] d;
    logic v;
    frame_start = 1;
    repeat (65537) @(posedge clk);
    #1 frame_start = 0;
    exp_fcnt = exp_fcnt + 16'd1;
    bus_rd(5'd19, d, v);
    checks++;
    if (d !== {15'b0, exp_fcnt, 1'b0}) begin
      errors++; $display("FAIL frame_wrap got %h want %h", d, {15'b0, exp_fcnt, 1'b0});
    end
    checks++;
    if (o[0] !== 8'h01 || rest !== '0) begin
      errors++; $display("FAIL wrap_live got %h/%h want 01/0", o[0], rest);
    end
  endtask

  task automatic test_rw_same();
    logic [31:0] d;
    logic v;
    addr = 5'd9; wdata = 32'h07; wr = 1; rd = 1;
    @(posedge clk); #1;
    wr = 0; rd = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      errors++; $display("FAIL rw_old got %b/%h want 1/0", rvalid, rdata);
    end
    bus_rd(5'd9, d, v);
    checks++;
    if (d !== 32'h07) begin
      errors++; $display("FAIL rw_new got %h want 07", d);
    end
  endtask

`ifdef GAME_REGS_SHADOW_EN
  task automatic test_staging();
    logic [31:0] d;
    logic v;
    bus_wr(5'd8, 32'hAB00_001E);
    bus_rd(5'd8, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h1E) begin
      errors++; $display("FAIL stage_rd got %b/%h want 1/1e", v, d);
    end
    pulse_frame();
    checks++;
    if (o[8] !== 8'h00) begin
      errors++; $display("FAIL hp_early got %h want 00", o[8]);
    end
    bus_wr(5'd18, 32'h1);
    checks++;
    if (pend !== 1'b1) begin
      errors++; $display("FAIL pend_set got %b want 1", pend);
    end
    bus_wr(5'd18, 32'h1);
    pulse_frame();
    checks++;
    if (o[8] !== 8'h1E || pend !== 1'b0) begin
      errors++; $display("FAIL hp_commit got %h/%b want 1e/0", o[8], pend);
    end
    checks++;
    if (o[9] !== 8'h07 || o[0] !== 8'h01) begin
      errors++; $display("FAIL other_copy got %h/%h want 07/01", o[9], o[0]);
    end
    bus_rd(5'd19, d, v);
    checks++;
    if (d !== {15'b0, exp_fcnt, 1'b0}) begin
      errors++; $display("FAIL status got %h want %h", d, {15'b0, exp_fcnt, 1'b0});
    end
  endtask

  task automatic test_commit_same_edge();
    bus_wr(5'd12, 32'h14);
    bus_wr(5'd18, 32'h2);
    checks++;
    if (pend !== 1'b0) begin
      errors++; $display("FAIL commit_bit0 got %b want 0", pend);
    end
    addr = 5'd18; wdata = 32'h1; wr = 1; frame_start = 1;
    @(posedge clk); #1;
    wr = 0; frame_start = 0;
    exp_fcnt = exp_fcnt + 16'd1;
    checks++;
    if (o[12] !== 8'h14 || pend !== 1'b0) begin
      errors++; $display("FAIL same_edge got %h/%b want 14/0", o[12], pend);
    end
  endtask

  task automatic test_write_on_copy();
    logic [31:0] d;
    logic v;
    bus_wr(5'd11, 32'h02);
    bus_wr(5'd18, 32'h1);
    addr = 5'd11; wdata = 32'h03; wr = 1; frame_start = 1;
    @(posedge clk); #1;
    wr = 0; frame_start = 0;
    exp_fcnt = exp_fcnt + 16'd1;
    checks++;
    if (o[11] !== 8'h02 || pend !== 1'b0) begin
      errors++; $display("FAIL copy_race got %h/%b want 02/0", o[11], pend);
    end
    bus_rd(5'd11, d, v);
    checks++;
    if (d !== 32'h03) begin
      errors++; $display("FAIL copy_stage got %h want 03", d);
    end
  endtask

  task automatic test_reset_pending();
    bus_wr(5'd13, 32'h55);
    bus_wr(5'd18, 32'h1);
    #2 rst_n = 0;
    #1;
    checks++;
    if (pend !== 1'b0 || o[8] !== 8'h00) begin
      errors++; $display("FAIL async_rst got %b/%h want 0/00", pend, o[8]);
    end
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    pulse_frame();
    checks++;
    if (o[13] !== 8'h00 || o[0] !== 8'h01) begin
      errors++; $display("FAIL rst_discard got %h/%h want 00/01", o[13], o[0]);
    end
  endtask
`else
  task automatic test_direct();
    logic [31:0] d;
    logic v;
    bus_wr(5'd14, 32'h02);
    checks++;
    if (o[14] !== 8'h02) begin
      errors++; $display("FAIL direct_buff got %h want 02", o[14]);
    end
    bus_wr(5'd0, 32'h05);
    checks++;
    if (o[0] !== 8'h05) begin
      errors++; $display("FAIL direct_screen got %h want 05", o[0]);
    end
    bus_wr(5'd18, 32'h1);
    checks++;
    if (pend !== 1'b0) begin
      errors++; $display("FAIL nocommit got %b want 0", pend);
    end
    bus_rd(5'd14, d, v);
    checks++;
    if (d !== 32'h02) begin
      errors++; $display("FAIL direct_rd got %h want 02", d);
    end
    pulse_frame();
    bus_rd(5'd19, d, v);
    checks++;
    if (d !== {15'b0, exp_fcnt, 1'b0}) begin
      errors++; $display("FAIL status got %h want %h", d, {15'b0, exp_fcnt, 1'b0});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reserved();
    test_frame_wrap();
    test_rw_same();
`ifdef GAME_REGS_SHADOW_EN
    checks++;
    if (o[9] !== 8'h00) begin
      errors++; $display("FAIL shield_staged got %h want 00", o[9]);
    end
    test_staging();
    test_commit_same_edge();
    test_write_on_copy();
    test_reset_pending();
`else
    checks++;
    if (o[9] !== 8'h07) begin
      errors++; $display("FAIL shield_direct got %h want 07", o[9]);
    end
    test_direct();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
